// File: rtl/uart_center_transmit.sv
// Transmit side of the UART pair: fetches a length-prefixed byte ring over an
// Avalon-MM read master and sends each byte as an 8N1 frame, LSB first, on tx.
module uart_center_transmit #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 1228800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        control_transmit_enable,
  input  logic [15:0] control_transmit_start_addr,
  input  logic [15:0] control_transmit_stop_addr,
  output logic        control_transmit_work,
  output logic        control_transmit_done,
  output logic        tx,
  output logic        avm_m1_read,
  output logic [15:0] avm_m1_address,
  input  logic        avm_m1_waitrequest,
  input  logic        avm_m1_readdatavalid,
  input  logic [31:0] avm_m1_readdata
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W    = $clog2(BAUD_DIV + 2);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_DIV);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(BAUD_DIV + 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_RD = 3'd1,
    S_LEN_WT = 3'd2,
    S_DAT_RD = 3'd3,
    S_DAT_WT = 3'd4,
    S_SEND   = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  function automatic logic [15:0] next_addr(input logic [15:0] a,
                                            input logic [15:0] first,
                                            input logic [15:0] last);
    if (a == last) next_addr = first;
    else           next_addr = a + 16'd1;
  endfunction

  function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
    case (lane)
      2'd0:    lane_byte = word[7:0];
      2'd1:    lane_byte = word[15:8];
      2'd2:    lane_byte = word[23:16];
      default: lane_byte = word[31:24];
    endcase
  endfunction

  // Slot 0 is the start bit, 1..8 carry d0..d7, anything else is the stop bit.
  function automatic logic slot_bit(input logic [7:0] data, input logic [3:0] slot);
    case (slot)
      4'd0:    slot_bit = 1'b0;
      4'd1:    slot_bit = data[0];
      4'd2:    slot_bit = data[1];
      4'd3:    slot_bit = data[2];
      4'd4:    slot_bit = data[3];
      4'd5:    slot_bit = data[4];
      4'd6:    slot_bit = data[5];
      4'd7:    slot_bit = data[6];
      4'd8:    slot_bit = data[7];
      default: slot_bit = 1'b1;
    endcase
  endfunction

  state_t           state_r, state_s;
  logic [15:0]      addr_r, addr_s;
  logic [7:0]       len_r, len_s, len_dec_s;
  logic [7:0]       shift_r, shift_s, rd_byte_s;
  logic [3:0]       bitcnt_r, bitcnt_s;
  logic [CNT_W-1:0] baud_cnt_r, baud_cnt_s;
  logic             tx_r, tx_s;
  logic             read_r, read_s;
  logic [15:0]      address_r;
  logic             work_r, work_s;
  logic             done_r, done_s;
  logic             slot_end_s;

  // Next-state, datapath and output decode for the fetch/serialise sequencer.
  always_comb begin
    state_s    = state_r;
    addr_s     = addr_r;
    len_s      = len_r;
    shift_s    = shift_r;
    bitcnt_s   = bitcnt_r;
    baud_cnt_s = baud_cnt_r;
    tx_s       = 1'b1;
    work_s     = work_r;
    done_s     = 1'b0;
    rd_byte_s  = lane_byte(avm_m1_readdata, addr_r[1:0]);
    len_dec_s  = len_r - 8'd1;
    // tx trails the slot counter by one clock, so the stop slot runs one
    // extra count to let the line-level stop bit finish before leaving SEND.
    if (bitcnt_r == 4'd9) slot_end_s = (baud_cnt_r == STOP_LAST);
    else                  slot_end_s = (baud_cnt_r == BIT_LAST);

    if (!control_transmit_enable) begin
      state_s    = S_IDLE;
      work_s     = 1'b0;
      bitcnt_s   = 4'd0;
      baud_cnt_s = CNT_ZERO;
    end else begin
      case (state_r)
        S_IDLE: begin
          state_s = S_LEN_RD;
          addr_s  = control_transmit_start_addr;
          work_s  = 1'b1;
        end
        S_LEN_RD: begin
          if (!avm_m1_waitrequest) state_s = S_LEN_WT;
          else                     state_s = S_LEN_RD;
        end
        S_LEN_WT: begin
          if (avm_m1_readdatavalid) begin
            len_s = rd_byte_s;
            if (rd_byte_s == 8'd0) begin
              state_s = S_DONE;
              done_s  = 1'b1;
              work_s  = 1'b0;
            end else begin
              addr_s  = next_addr(addr_r, control_transmit_start_addr, control_transmit_stop_addr);
              state_s = S_DAT_RD;
            end
          end else begin
            state_s = S_LEN_WT;
          end
        end
        S_DAT_RD: begin
          if (!avm_m1_waitrequest) state_s = S_DAT_WT;
          else                     state_s = S_DAT_RD;
        end
        S_DAT_WT: begin
          if (avm_m1_readdatavalid) begin
            shift_s    = rd_byte_s;
            bitcnt_s   = 4'd0;
            baud_cnt_s = CNT_ZERO;
            state_s    = S_SEND;
          end else begin
            state_s = S_DAT_WT;
          end
        end
        S_SEND: begin
          tx_s = slot_bit(shift_r, bitcnt_r);
          if (slot_end_s) begin
            baud_cnt_s = CNT_ZERO;
            if (bitcnt_r == 4'd9) begin
              bitcnt_s = 4'd0;
              len_s    = len_dec_s;
              if (len_dec_s == 8'd0) begin
                state_s = S_DONE;
                done_s  = 1'b1;
                work_s  = 1'b0;
              end else begin
                addr_s  = next_addr(addr_r, control_transmit_start_addr, control_transmit_stop_addr);
                state_s = S_DAT_RD;
              end
            end else begin
              bitcnt_s = bitcnt_r + 4'd1;
            end
          end else begin
            baud_cnt_s = baud_cnt_r + CNT_ONE;
          end
        end
        S_DONE: begin
          state_s = S_DONE;
        end
        default: begin
          state_s = S_IDLE;
          work_s  = 1'b0;
        end
      endcase
    end

    read_s = (state_s == S_LEN_RD) || (state_s == S_DAT_RD);
  end

  // State and datapath registers; every output is driven from a flop here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= S_IDLE;
      addr_r     <= 16'd0;
      len_r      <= 8'd0;
      shift_r    <= 8'd0;
      bitcnt_r   <= 4'd0;
      baud_cnt_r <= CNT_ZERO;
      tx_r       <= 1'b1;
      read_r     <= 1'b0;
      address_r  <= 16'd0;
      work_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      addr_r     <= addr_s;
      len_r      <= len_s;
      shift_r    <= shift_s;
      bitcnt_r   <= bitcnt_s;
      baud_cnt_r <= baud_cnt_s;
      tx_r       <= tx_s;
      read_r     <= read_s;
      address_r  <= {addr_s[15:2], 2'b00};
      work_r     <= work_s;
      done_r     <= done_s;
    end
  end

  assign tx                    = tx_r;
  assign avm_m1_read           = read_r;
  assign avm_m1_address        = address_r;
  assign control_transmit_work = work_r;
  assign control_transmit_done = done_r;

endmodule

// File: tb/tb_uart_center_transmit.sv
// Self-checking bench for uart_center_transmit: byte-addressed memory behind an
// Avalon responder, a line monitor decoding 8N1 frames, and queue scoreboards.
module tb_uart_center_transmit;

  typedef struct packed {
    logic [7:0] data;
    logic       err;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [15:0] start_addr = 16'h0000;
  logic [15:0] stop_addr = 16'h0000;
  logic        work, done, tx, read;
  logic [15:0] address;
  logic        waitreq = 1'b0;
  logic        rdv = 1'b0;
  logic [31:0] rdata = 32'h0;

  logic [7:0]  mem [0:65535];
  int          n_vec = 0;
  int          n_err = 0;

  int          stall_left = 0;
  bit          pending = 1'b0;
  logic [31:0] pend_data = 32'h0;
  int          rd_count = 0;
  int          overlap_rd = 0;
  logic [15:0] rd_log[$];
  int          done_count = 0;
  int          done_work_err = 0;
  int          fall_count = 0;
  int          cyc = 0;

  bit          mon_act = 1'b0;
  int          mon_off = 0;
  logic [9:0]  mon_bits = 10'h0;
  bit          mon_err = 1'b0;
  logic        prev_tx = 1'b1;
  int          last_end = -1;
  frame_t      obs_q[$];
  int          gap_q[$];

  logic [7:0]  exp_q[$];
  logic [15:0] exp_addr_q[$];

  uart_center_transmit #(.CLK_FREQ(50000000), .BAUD_RATE(1228800)) dut (
    .clk                         (clk),
    .rst                         (rst),
    .control_transmit_enable     (en),
    .control_transmit_start_addr (start_addr),
    .control_transmit_stop_addr  (stop_addr),
    .control_transmit_work       (work),
    .control_transmit_done       (done),
    .tx                          (tx),
    .avm_m1_read                 (read),
    .avm_m1_address              (address),
    .avm_m1_waitrequest          (waitreq),
    .avm_m1_readdatavalid        (rdv),
    .avm_m1_readdata             (rdata)
  );

  always #5 clk = ~clk;

  // Avalon responder (1-cycle read latency) and tx/done monitor, on the falling edge.
  initial begin
    logic [15:0] wa;
    forever begin
      @(negedge clk);
      cyc++;
      if (pending && read === 1'b1) overlap_rd++;
      rdv     = pending;
      rdata   = pend_data;
      pending = 1'b0;
      if (!rst) begin
        waitreq = 1'b0;
        rdv     = 1'b0;
      end else if (read === 1'b1) begin
        if (stall_left > 0) begin
          waitreq = 1'b1;
          stall_left--;
        end else begin
          waitreq   = 1'b0;
          wa        = {address[15:2], 2'b00};
          pend_data = {mem[wa + 16'd3], mem[wa + 16'd2], mem[wa + 16'd1], mem[wa]};
          pending   = 1'b1;
          rd_count++;
          rd_log.push_back(address);
        end
      end else begin
        waitreq = 1'b0;
      end

      if (done === 1'b1) begin
        done_count++;
        if (work !== 1'b0) done_work_err++;
      end
      if (!rst) begin
        mon_act = 1'b0;
      end else if (!mon_act && prev_tx === 1'b1 && tx === 1'b0) begin
        mon_act = 1'b1;
        mon_off = 0;
        mon_err = 1'b0;
        fall_count++;
        if (last_end >= 0) gap_q.push_back(cyc - last_end);
      end
      if (mon_act) begin
        for (int i = 0; i < 10; i++) begin
          if (mon_off == 41 * i) mon_bits[i] = tx;
          else if (mon_off == 41 * i + 40 && tx !== mon_bits[i]) mon_err = 1'b1;
        end
        if (mon_off == 409) begin
          if (mon_bits[0] !== 1'b0 || mon_bits[9] !== 1'b1) mon_err = 1'b1;
          obs_q.push_back({mon_bits[8:1], mon_err});
          mon_act  = 1'b0;
          last_end = cyc + 1;
        end
        mon_off++;
      end
      prev_tx = tx;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clear_logs();
    rd_log.delete(); obs_q.delete(); gap_q.delete();
    exp_q.delete(); exp_addr_q.delete();
    rd_count = 0; done_count = 0; done_work_err = 0; fall_count = 0;
    overlap_rd = 0; last_end = -1; stall_left = 0;
  endtask

  task automatic wait_done(input int limit, output bit ok);
    int base;
    base = done_count;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      tick(1);
      if (done_count > base) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_fall(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      tick(1);
      if (fall_count > 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b0;
    tick(3);
    n_vec++;
    if (tx !== 1'b1 || read !== 1'b0 || address !== 16'h0000 || work !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_values: tx=%b read=%b addr=%h work=%b done=%b, required 1 0 0000 0 0", tx, read, address, work, done);
    end
    rst = 1'b1;
    tick(5);
    n_vec++;
    if (tx !== 1'b1 || read !== 1'b0 || work !== 1'b0) begin
      n_err++;
      $display("FAIL idle_disabled: tx=%b read=%b work=%b, required 1 0 0", tx, read, work);
    end
  endtask

  task automatic test_normal();
    bit ok;
    logic [7:0] e;
    frame_t f;
    logic [15:0] ea;
    clear_logs();
    mem[16'h0010] = 8'h02; mem[16'h0011] = 8'h55; mem[16'h0012] = 8'hA3;
    start_addr = 16'h0010; stop_addr = 16'h00FF;
    exp_q.push_back(8'h55); exp_q.push_back(8'hA3);
    repeat (3) exp_addr_q.push_back(16'h0010);
    en = 1'b1;
    tick(1);
    n_vec++;
    if (read !== 1'b1 || address !== 16'h0010 || work !== 1'b1) begin
      n_err++;
      $display("FAIL normal_first_read: read=%b addr=%h work=%b, required 1 0010 1", read, address, work);
    end
    wait_done(3000, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL normal_done_timeout: done not seen, required one pulse"); end
    n_vec++;
    if (done_count !== 1 || done_work_err !== 0) begin
      n_err++;
      $display("FAIL normal_done_pulse: pulses=%0d work_overlap=%0d, required 1 0", done_count, done_work_err);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vec++;
      if (obs_q.size() == 0) begin
        n_err++; $display("FAIL normal_frame: missing, required %h", e);
      end else begin
        f = obs_q.pop_front();
        if (f.data !== e || f.err !== 1'b0) begin
          n_err++; $display("FAIL normal_frame: got %h err=%b, required %h err=0", f.data, f.err, e);
        end
      end
    end
    n_vec++;
    if (rd_count !== exp_addr_q.size() || obs_q.size() !== 0) begin
      n_err++;
      $display("FAIL normal_counts: reads=%0d extra_frames=%0d, required %0d 0", rd_count, obs_q.size(), exp_addr_q.size());
    end
    while (exp_addr_q.size() > 0 && rd_log.size() > 0) begin
      ea = exp_addr_q.pop_front();
      n_vec++;
      if (rd_log[0] !== ea) begin n_err++; $display("FAIL normal_addr: got %h, required %h", rd_log[0], ea); end
      void'(rd_log.pop_front());
    end
    n_vec++;
    if (gap_q.size() !== 1 || gap_q[0] < 3) begin
      n_err++;
      $display("FAIL normal_gap: gaps=%0d first=%0d, required 1 gap >= 3", gap_q.size(), (gap_q.size() > 0) ? gap_q[0] : -1);
    end
    tick(30);
    n_vec++;
    if (rd_count !== 3 || done_count !== 1 || work !== 1'b0 || tx !== 1'b1) begin
      n_err++;
      $display("FAIL normal_hold_done: reads=%0d done=%0d work=%b tx=%b, required 3 1 0 1", rd_count, done_count, work, tx);
    end
    en = 1'b0;
    tick(3);
  endtask

  task automatic test_zero_len();
    bit ok;
    clear_logs();
    mem[16'h0040] = 8'h00;
    start_addr = 16'h0040; stop_addr = 16'h00FF;
    en = 1'b1;
    wait_done(200, ok);
    tick(5);
    n_vec++;
    if (!ok || done_count !== 1 || work !== 1'b0) begin
      n_err++;
      $display("FAIL zero_done: seen=%b pulses=%0d work=%b, required 1 1 0", ok, done_count, work);
    end
    n_vec++;
    if (rd_count !== 1 || rd_log.size() == 0 || rd_log[0] !== 16'h0040) begin
      n_err++;
      $display("FAIL zero_reads: reads=%0d, required exactly 1 at 0040", rd_count);
    end
    n_vec++;
    if (fall_count !== 0 || tx !== 1'b1) begin
      n_err++;
      $display("FAIL zero_tx_idle: falls=%0d tx=%b, required 0 1", fall_count, tx);
    end
    en = 1'b0;
    tick(3);
  endtask

  task automatic test_ring_wrap();
    bit ok;
    logic [7:0] e;
    frame_t f;
    clear_logs();
    mem[16'h0020] = 8'h03; mem[16'h0021] = 8'h11; mem[16'h0022] = 8'h22; mem[16'h0023] = 8'hEE;
    start_addr = 16'h0020; stop_addr = 16'h0022;
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h03);
    en = 1'b1;
    wait_done(3000, ok);
    n_vec++;
    if (!ok || done_count !== 1) begin
      n_err++; $display("FAIL ring_done: seen=%b pulses=%0d, required 1 1", ok, done_count);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vec++;
      if (obs_q.size() == 0) begin
        n_err++; $display("FAIL ring_frame: missing, required %h", e);
      end else begin
        f = obs_q.pop_front();
        if (f.data !== e || f.err !== 1'b0) begin
          n_err++; $display("FAIL ring_frame: got %h err=%b, required %h err=0", f.data, f.err, e);
        end
      end
    end
    n_vec++;
    if (rd_count !== 4 || rd_log.size() < 3 || rd_log[2] !== 16'h0020) begin
      n_err++;
      $display("FAIL ring_reads: reads=%0d third=%h, required 4 0020", rd_count, (rd_log.size() > 2) ? rd_log[2] : 16'hFFFF);
    end
    en = 1'b0;
    tick(3);
  endtask

  task automatic test_stall();
    bit ok;
    bit addr_bad;
    int hi;
    frame_t f;
    clear_logs();
    mem[16'h0080] = 8'h01; mem[16'h0081] = 8'h3C;
    start_addr = 16'h0080; stop_addr = 16'h00FF;
    exp_q.push_back(8'h3C);
    stall_left = 5;
    en = 1'b1;
    hi = 0; addr_bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (read === 1'b1) begin
        hi++;
        if (address !== 16'h0080) addr_bad = 1'b1;
      end else if (hi > 0) begin
        break;
      end
    end
    n_vec++;
    if (hi !== 6 || addr_bad) begin
      n_err++; $display("FAIL stall_hold: read cycles=%0d addr_moved=%b, required 6 0", hi, addr_bad);
    end
    wait_done(1000, ok);
    n_vec++;
    if (!ok || done_count !== 1 || rd_count !== 2 || overlap_rd !== 0) begin
      n_err++;
      $display("FAIL stall_done: seen=%b pulses=%0d reads=%0d overlap=%0d, required 1 1 2 0", ok, done_count, rd_count, overlap_rd);
    end
    n_vec++;
    if (obs_q.size() == 0) begin
      n_err++; $display("FAIL stall_frame: missing, required %h", exp_q[0]);
    end else begin
      f = obs_q.pop_front();
      if (f.data !== exp_q[0] || f.err !== 1'b0) begin
        n_err++; $display("FAIL stall_frame: got %h err=%b, required %h err=0", f.data, f.err, exp_q[0]);
      end
    end
    en = 1'b0;
    tick(3);
  endtask

  task automatic test_abort();
    bit ok;
    logic [7:0] garbled;
    logic [7:0] e;
    frame_t f;
    clear_logs();
    mem[16'h00A0] = 8'h02; mem[16'h00A1] = 8'h5A; mem[16'h00A2] = 8'hC3;
    start_addr = 16'h00A0; stop_addr = 16'h00FF;
    en = 1'b1;
    wait_fall(200, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL abort_start_timeout: no start bit, required one"); end
    tick(180);
    en = 1'b0;
    tick(1);
    n_vec++;
    if (tx !== 1'b1 || work !== 1'b0 || read !== 1'b0) begin
      n_err++; $display("FAIL abort_outputs: tx=%b work=%b read=%b, required 1 0 0", tx, work, read);
    end
    tick(500);
    garbled = 8'h5A | 8'hF0;
    n_vec++;
    if (done_count !== 0 || rd_count !== 2 || obs_q.size() !== 1 || obs_q[0].data !== garbled) begin
      n_err++;
      $display("FAIL abort_quiet: done=%0d reads=%0d frames=%0d data=%h, required 0 2 1 %h", done_count, rd_count, obs_q.size(),
               (obs_q.size() > 0) ? obs_q[0].data : 8'h00, garbled);
    end
    clear_logs();
    exp_q.push_back(8'h5A); exp_q.push_back(8'hC3);
    en = 1'b1;
    tick(1);
    n_vec++;
    if (read !== 1'b1 || address !== 16'h00A0) begin
      n_err++; $display("FAIL abort_restart: read=%b addr=%h, required 1 00A0", read, address);
    end
    wait_done(3000, ok);
    n_vec++;
    if (!ok || done_count !== 1 || rd_count !== 3) begin
      n_err++; $display("FAIL abort_rerun: seen=%b pulses=%0d reads=%0d, required 1 1 3", ok, done_count, rd_count);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_vec++;
      if (obs_q.size() == 0) begin
        n_err++; $display("FAIL abort_frame: missing, required %h", e);
      end else begin
        f = obs_q.pop_front();
        if (f.data !== e || f.err !== 1'b0) begin
          n_err++; $display("FAIL abort_frame: got %h err=%b, required %h err=0", f.data, f.err, e);
        end
      end
    end
    en = 1'b0;
    tick(3);
  endtask

  task automatic test_async_reset();
    bit ok;
    frame_t f;
    clear_logs();
    mem[16'h00C0] = 8'h01; mem[16'h00C1] = 8'h00;
    start_addr = 16'h00C0; stop_addr = 16'h00FF;
    en = 1'b1;
    wait_fall(200, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL areset_start_timeout: no start bit, required one"); end
    tick(10);
    #1 rst = 1'b0;
    #1;
    n_vec++;
    if (tx !== 1'b1 || read !== 1'b0 || work !== 1'b0 || done !== 1'b0 || address !== 16'h0000) begin
      n_err++;
      $display("FAIL areset_immediate: tx=%b read=%b work=%b done=%b addr=%h, required 1 0 0 0 0000", tx, read, work, done, address);
    end
    tick(3);
    clear_logs();
    exp_q.push_back(8'h00);
    rst = 1'b1;
    tick(1);
    n_vec++;
    if (read !== 1'b1 || address !== 16'h00C0) begin
      n_err++; $display("FAIL areset_refetch: read=%b addr=%h, required 1 00C0", read, address);
    end
    wait_done(1000, ok);
    n_vec++;
    if (!ok || done_count !== 1 || rd_count !== 2 || obs_q.size() !== 1) begin
      n_err++;
      $display("FAIL areset_rerun: seen=%b pulses=%0d reads=%0d frames=%0d, required 1 1 2 1", ok, done_count, rd_count, obs_q.size());
    end else begin
      f = obs_q.pop_front();
      n_vec++;
      if (f.data !== exp_q[0] || f.err !== 1'b0) begin
        n_err++; $display("FAIL areset_frame: got %h err=%b, required %h err=0", f.data, f.err, exp_q[0]);
      end
    end
    en = 1'b0;
    tick(3);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    test_reset();
    test_normal();
    test_zero_len();
    test_ring_wrap();
    test_stall();
    test_abort();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
